// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_exc_ctrl_pkg: shared CP0 exception codes, register addresses and sequencer encodings
package cp0_exc_ctrl_pkg;
  localparam logic [4:0] EX_INT  = 5'h00;
  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_ADES = 5'h05;
  localparam logic [4:0] EX_SYS  = 5'h08;
  localparam logic [4:0] EX_BP   = 5'h09;
  localparam logic [4:0] EX_RI   = 5'h0a;
  localparam logic [4:0] EX_OV   = 5'h0c;
  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_COMMIT, ST_FLUSH} state_t;
  typedef enum logic [1:0] {K_INT, K_EXC, K_ERET} kind_t;
endpackage

// File: rtl/cp0_exc_ctrl_int_detect.sv
// cp0_int_detect: pending-interrupt mask and global interrupt request
module cp0_int_detect (
  input  logic       status_ie,
  input  logic       status_exl,
  input  logic [7:0] status_im,
  input  logic [7:0] cause_ip,
  output logic       int_req
);
  logic [7:0] pending;
  always_comb begin
    pending = status_im & cause_ip;
    int_req = status_ie & ~status_exl & |pending;
  end
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: trap decision, drain, CP0 commit pulse and pipeline flush sequencer
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          DRAIN_MAX  = 64,
  parameter int          CNT_W      = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        m_ex,
  input  logic [4:0]  m_excode,
  input  logic [31:0] m_badvaddr,
  input  logic        m_eret,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [7:0]  cause_ip,
  input  logic [31:0] epc,
  input  logic        div_busy,
  input  logic        bus_pending,
  output logic        m_ready,
  output logic        cp0_ex,
  output logic        eret_flush,
  output logic [4:0]  cp0_excode,
  output logic [31:0] cp0_pc,
  output logic        cp0_bd,
  output logic [31:0] cp0_badvaddr,
  output logic        div_cancel,
  output logic        pipe_flush,
  output logic [31:0] flush_pc,
  output logic        drain_timeout
);
  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [4:0]        excode_q, excode_d;
  logic [31:0]       pc_q, pc_d;
  logic              bd_q, bd_d;
  logic [31:0]       bva_q, bva_d;
  logic              int_req, evt, busy, cnt_hit;

  cp0_int_detect u_int (
    .status_ie  (status_ie),
    .status_exl (status_exl),
    .status_im  (status_im),
    .cause_ip   (cause_ip),
    .int_req    (int_req)
  );

  always_comb begin
    evt     = m_valid & (int_req | m_ex | m_eret);
    busy    = div_busy | bus_pending;
    cnt_hit = cnt_q == CNT_W'(DRAIN_MAX - 1);
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = '0;
    timeout_d = timeout_q;
    excode_d  = excode_q;
    pc_d      = pc_q;
    bd_d      = bd_q;
    bva_d     = bva_q;
    case (state_q)
      ST_IDLE: if (evt) begin
        state_d = busy ? ST_DRAIN : ST_COMMIT;
        kind_d  = int_req ? K_INT : m_ex ? K_EXC : K_ERET;
        if (int_req | m_ex) begin
          pc_d     = m_pc;
          bd_d     = m_bd;
          excode_d = int_req ? EX_INT : m_excode;
        end
        if (~int_req & m_ex) bva_d = m_badvaddr;
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (~busy | cnt_hit) begin
          state_d = ST_COMMIT;
          cnt_d   = '0;
        end
        if (busy & cnt_hit) timeout_d = 1'b1;
      end
      ST_COMMIT: state_d = ST_FLUSH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // pulses are gated by resetn so an aborted sequence emits nothing in the reset cycle
  always_comb begin
    m_ready       = (state_q == ST_IDLE) & ~evt;
    cp0_ex        = resetn & (state_q == ST_COMMIT) & (kind_q != K_ERET);
    eret_flush    = resetn & (state_q == ST_COMMIT) & (kind_q == K_ERET);
    div_cancel    = resetn & (state_q == ST_IDLE) & evt & div_busy;
    pipe_flush    = resetn & (state_q == ST_FLUSH);
    flush_pc      = (kind_q == K_ERET) ? epc : EXC_VECTOR;
    cp0_excode    = excode_q;
    cp0_pc        = pc_q;
    cp0_bd        = bd_q;
    cp0_badvaddr  = bva_q;
    drain_timeout = timeout_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      kind_q    <= K_INT;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      excode_q  <= '0;
      pc_q      <= '0;
      bd_q      <= 1'b0;
      bva_q     <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      excode_q  <= excode_d;
      pc_q      <= pc_d;
      bd_q      <= bd_d;
      bva_q     <= bva_d;
    end
  end
endmodule
